pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_ctrl_lu_detect.sv | 21 ++
 rtl/pipe_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and default widths for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL_LU = 2'd1,
    HOLD_MEM = 2'd2,
    FLUSH    = 2'd3
  } pc_state_t;

endpackage

// File: rtl/pipe_ctrl_lu_detect.sv
// Load-use hazard compare: the ID instruction reads the register an EX load is about to write.
module lu_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              lu_hazard
);

  // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu_hazard = ex_is_load && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with saturating stall and flush counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow, all stages advance
// STALL_LU | one bubble inserted after a load-use stall
// HOLD_MEM | whole pipe frozen on mem_busy, taken branch may be pending
// FLUSH    | one cycle after a redirect, wrong-path work already squashed
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_taken,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              pc_redirect,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  pc_state_t state, state_nxt;
  logic      pend_flush, pend_nxt;
  logic      lu_hazard;
  logic      taken_eff;

  lu_detect #(.REG_AW(REG_AW)) u_lu_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .lu_hazard  (lu_hazard)
  );

  // pend_flush is only ever set while holding, so OR-ing it in covers the HOLD_MEM exit.
  assign taken_eff = ex_taken || pend_flush;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    pc_redirect = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    state_nxt   = RUN;
    pend_nxt    = pend_flush;
    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pend_nxt   = 1'b0;
    end else if (mem_busy) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
      state_nxt = HOLD_MEM;
      pend_nxt  = pend_flush || ex_taken;
    end else if (taken_eff) begin
      pc_redirect = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      pend_nxt    = 1'b0;
      state_nxt   = FLUSH;
    end else if (lu_hazard && (state != STALL_LU) && (state != FLUSH)) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      state_nxt  = STALL_LU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pend_flush <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_flush <= pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (pc_redirect && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized bench for pipe_ctrl against an event-level reference model.
module tb_pipe_ctrl;

  localparam int CW   = 4;
  localparam int AW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_is_load, ex_taken, mem_busy;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          pc_redirect, ifid_flush, idex_flush;
  logic [1:0]    state_o;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.CNT_W(CW), .REG_AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .ex_taken    (ex_taken),
    .mem_busy    (mem_busy),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .pc_redirect (pc_redirect),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .state_o     (state_o),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model remembers what the pipe did on the previous cycle, not an encoded state.
  string last_act = "none";
  bit    pend     = 1'b0;
  bit    known    = 1'b0;
  int    m_stall  = 0;
  int    m_flush  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  function automatic int act_state(input string a);
    case (a)
      "stall": return 1;
      "hold":  return 2;
      "flush": return 3;
      default: return 0;
    endcase
  endfunction

  task automatic step(input bit r, input bit mb, input bit tk, input bit ld,
                      input int rd, input int r1, input int r2,
                      input bit u1, input bit u2);
    bit       lu;
    bit [7:0] exp_ctl;
    @(negedge clk);
    rst = r; mem_busy = mb; ex_taken = tk; ex_is_load = ld;
    ex_rd = AW'(rd); id_rs1 = AW'(r1); id_rs2 = AW'(r2);
    id_use_rs1 = u1; id_use_rs2 = u2;
    #1;
    lu = ld && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
    if (known) begin
      chk("state", 32'(state_o), 32'(act_state(last_act)));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    end
    // exp_ctl = {pc,ifid,idex,exmem,memwb enables, redirect, ifid_flush, idex_flush}
    if (r) begin
      exp_ctl = 8'b11111_011;
      last_act = "none"; pend = 1'b0; m_stall = 0; m_flush = 0; known = 1'b1;
    end else if (mb) begin
      exp_ctl = 8'b00000_000;
      pend = pend | tk; last_act = "hold"; m_stall = sat_inc(m_stall);
    end else if (tk || pend) begin
      exp_ctl = 8'b11111_111;
      pend = 1'b0; last_act = "flush"; m_flush = sat_inc(m_flush);
    end else if (lu && last_act != "stall" && last_act != "flush") begin
      exp_ctl = 8'b00111_001;
      last_act = "stall"; m_stall = sat_inc(m_stall);
    end else begin
      exp_ctl = 8'b11111_000;
      last_act = "none";
    end
    chk("ctl", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    pc_redirect, ifid_flush, idex_flush}), 32'(exp_ctl));
  endtask

  task automatic post(input string tag, input int st, input int sc, input int fc);
    @(posedge clk); #1;
    chk({tag, "_state"}, 32'(state_o), 32'(st));
    chk({tag, "_stall"}, 32'(stall_cnt), 32'(sc));
    chk({tag, "_flush"}, 32'(flush_cnt), 32'(fc));
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    do_reset();
    post("rst", 0, 0, 0);

    // load-use stall, then stall condition ignored for one cycle
    step(0, 0, 0, 1, 5, 5, 0, 1, 0);
    post("lu", 1, 1, 0);
    step(0, 0, 0, 1, 5, 5, 0, 1, 0);
    post("lu_after", 0, 1, 0);

    do_reset();
    step(0, 0, 0, 1, 0, 0, 0, 1, 0);
    post("lu_x0", 0, 0, 0);

    do_reset();
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    post("taken", 3, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    post("taken_after", 0, 0, 1);

    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    post("hold_taken", 3, 3, 1);

    do_reset();
    step(0, 0, 1, 1, 7, 3, 7, 0, 1);
    post("lu_and_taken", 3, 0, 1);

    do_reset();
    for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    post("sat", 2, CMAX, 0);
    do_reset();
    post("sat_rst", 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    post("no_redirect", 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 50),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
